// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU/writeback encodings, x0 index, and the
// control bundle carried down the pipeline with its bubble value.
package riscv_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd9;

  localparam logic [1:0] RUSRC_ALU = 2'd0;
  localparam logic [1:0] RUSRC_MEM = 2'd1;
  localparam logic [1:0] RUSRC_PC4 = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic               RUwr;
    logic               DMrd;
    logic               DMwr;
    logic               ALUsrc;
    logic [ALUOP_W-1:0] ALUop;
    logic [1:0]         RUdatasrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operand/control bundle in, EX-side registered copies out, plus the
// stall request back toward PC and IF/ID.
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
);
  logic [XLEN-1:0]    pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]         rs1_id, rs2_id, rd_id;
  logic               RUwr_id, DMrd_id, DMwr_id, ALUsrc_id;
  logic [ALUOP_W-1:0] ALUop_id;
  logic [1:0]         RUdatasrc_id;
  logic               flush_ex;

  logic [XLEN-1:0]    pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]         rs1_ex, rs2_ex, rd_ex;
  logic               RUwr_ex, DMrd_ex, DMwr_ex, ALUsrc_ex;
  logic [ALUOP_W-1:0] ALUop_ex;
  logic [1:0]         RUdatasrc_ex;
  logic               valid_ex;
  logic               stall_id;

  modport master (
    output pc_id, rs1_data_id, rs2_data_id, imm_id, rs1_id, rs2_id, rd_id,
           RUwr_id, DMrd_id, DMwr_id, ALUsrc_id, ALUop_id, RUdatasrc_id, flush_ex,
    input  pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
           RUwr_ex, DMrd_ex, DMwr_ex, ALUsrc_ex, ALUop_ex, RUdatasrc_ex,
           valid_ex, stall_id
  );

  modport slave (
    input  pc_id, rs1_data_id, rs2_data_id, imm_id, rs1_id, rs2_id, rd_id,
           RUwr_id, DMrd_id, DMwr_id, ALUsrc_id, ALUop_id, RUdatasrc_id, flush_ex,
    output pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
           RUwr_ex, DMrd_ex, DMwr_ex, ALUsrc_ex, ALUop_ex, RUdatasrc_ex,
           valid_ex, stall_id
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detection between the load in EX and the instruction in ID.
// Purely combinational; a branch flush suppresses the stall request.
module hazard_detect (
  input  logic       valid_ex,
  input  logic       DMrd_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       flush_ex,
  output logic       lu,
  output logic       stall_id
);
  import riscv_pkg::*;

  // rs2 is checked unconditionally so stores consuming a fresh load also stall.
  assign lu = valid_ex & DMrd_ex & (rd_ex != REG_X0) &
              ((rd_ex == rs1_id) | (rd_ex == rs2_id));

  // On a flush the ID instruction is wrong-path, so IF/ID must advance.
  assign stall_id = lu & ~flush_ex;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle ID->EX, inserts a bubble on flush or load-use.
// Stall is a single cycle since the bubble it creates cannot itself match.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            valid_q;
  ctrl_t           ctrl_q, ctrl_id;
  logic            lu, bubble;

  hazard_detect u_hazard (
    .valid_ex (valid_q),
    .DMrd_ex  (ctrl_q.DMrd),
    .rd_ex    (rd_q),
    .rs1_id   (bus.rs1_id),
    .rs2_id   (bus.rs2_id),
    .flush_ex (bus.flush_ex),
    .lu       (lu),
    .stall_id (bus.stall_id)
  );

  assign bubble = bus.flush_ex | lu;

  // Writes to x0 are dropped here so forwarding never matches on rd=0.
  always_comb begin
    ctrl_id           = CTRL_NOP;
    ctrl_id.RUwr      = bus.RUwr_id & (bus.rd_id != REG_X0);
    ctrl_id.DMrd      = bus.DMrd_id;
    ctrl_id.DMwr      = bus.DMwr_id;
    ctrl_id.ALUsrc    = bus.ALUsrc_id;
    ctrl_id.ALUop     = bus.ALUop_id;
    ctrl_id.RUdatasrc = bus.RUdatasrc_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
    end else if (bubble) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= bus.pc_id;
      rs1_data_q <= bus.rs1_data_id;
      rs2_data_q <= bus.rs2_data_id;
      imm_q      <= bus.imm_id;
      rs1_q      <= bus.rs1_id;
      rs2_q      <= bus.rs2_id;
      rd_q       <= bus.rd_id;
      ctrl_q     <= ctrl_id;
      valid_q    <= 1'b1;
    end
  end

  // Flush outranks load-use, so a simultaneous event counts only as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.flush_ex) begin
      if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end else if (lu) begin
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.pc_ex        = pc_q;
  assign bus.rs1_data_ex  = rs1_data_q;
  assign bus.rs2_data_ex  = rs2_data_q;
  assign bus.imm_ex       = imm_q;
  assign bus.rs1_ex       = rs1_q;
  assign bus.rs2_ex       = rs2_q;
  assign bus.rd_ex        = rd_q;
  assign bus.RUwr_ex      = ctrl_q.RUwr;
  assign bus.DMrd_ex      = ctrl_q.DMrd;
  assign bus.DMwr_ex      = ctrl_q.DMwr;
  assign bus.ALUsrc_ex    = ctrl_q.ALUsrc;
  assign bus.ALUop_ex     = ctrl_q.ALUop;
  assign bus.RUdatasrc_ex = ctrl_q.RUdatasrc;
  assign bus.valid_ex     = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with 4-bit counters to reach saturation.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int               n_checks = 0;
  int               n_errors = 0;
  int               exp_stall;

  id_ex_stage_if #(.XLEN(XLEN), .ALUOP_W(4)) bus ();

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data fields are derived from pc so captured values are easy to predict.
  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ruwr, input logic dmrd,
                        input logic dmwr, input logic [3:0] aluop);
    bus.pc_id        = pc;
    bus.rs1_data_id  = pc + 32'h1000;
    bus.rs2_data_id  = pc + 32'h2000;
    bus.imm_id       = pc + 32'h3000;
    bus.rs1_id       = rs1;
    bus.rs2_id       = rs2;
    bus.rd_id        = rd;
    bus.RUwr_id      = ruwr;
    bus.DMrd_id      = dmrd;
    bus.DMwr_id      = dmwr;
    bus.ALUsrc_id    = dmrd | dmwr;
    bus.ALUop_id     = aluop;
    bus.RUdatasrc_id = dmrd ? 2'd1 : 2'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush_ex = 1'b0;
    rst_n = 1'b0;
    set_id(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 4'h5);
    #2;
    check("rst_valid", bus.valid_ex, 0);
    check("rst_pc", bus.pc_ex, 0);
    check("rst_stall", bus.stall_id, 0);
    check("rst_cnts", {stall_cnt, flush_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("cap_valid", bus.valid_ex, 1);
    check("cap_pc", bus.pc_ex, 32'h100);
    check("cap_rs2data", bus.rs2_data_ex, 32'h2100);
    check("cap_rd", bus.rd_ex, 3);
    check("cap_ctrl", {bus.RUwr_ex, bus.DMrd_ex, bus.DMwr_ex, bus.ALUsrc_ex,
                       bus.ALUop_ex, bus.RUdatasrc_ex}, 10'b1101_0101_01);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bus.valid_ex, 0);
    check("async_pc", bus.pc_ex, 0);
    check("async_rd", bus.rd_ex, 0);
    check("async_imm", bus.imm_ex, 0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_valid", bus.valid_ex, 1);
    check("post_rst_rd", bus.rd_ex, 3);

    // Load-use on rs1
    set_id(32'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    set_id(32'h204, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 4'h2);
    #1 check("lu_stall", bus.stall_id, 1);
    step();
    check("lu_bubble_valid", bus.valid_ex, 0);
    check("lu_bubble_ruwr", bus.RUwr_ex, 0);
    check("lu_bubble_rd", bus.rd_ex, 0);
    check("lu_bubble_pc", bus.pc_ex, 0);
    check("lu_bubble_aluop", bus.ALUop_ex, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_stall_drop", bus.stall_id, 0);
    step();
    check("lu_resume_rs1", bus.rs1_ex, 5);
    check("lu_resume_valid", bus.valid_ex, 1);
    check("lu_resume_rd", bus.rd_ex, 7);
    check("lu_resume_pc", bus.pc_ex, 32'h204);

    // Load to x0 must neither write nor stall
    set_id(32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    check("ld_x0_ruwr", bus.RUwr_ex, 0);
    set_id(32'h304, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 4'h0);
    #1 check("ld_x0_nostall", bus.stall_id, 0);

    // Non-load producer does not stall
    set_id(32'h308, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    set_id(32'h30c, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 4'h0);
    #1 check("alu_nostall", bus.stall_id, 0);

    // Store consuming a load through rs2
    set_id(32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    set_id(32'h404, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 4'h0);
    #1 check("st_stall", bus.stall_id, 1);
    step();
    check("st_stall_cnt", stall_cnt, 2);

    // Flush outranks load-use
    set_id(32'h500, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    set_id(32'h504, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 4'h0);
    bus.flush_ex = 1'b1;
    #1 check("flush_nostall", bus.stall_id, 0);
    step();
    bus.flush_ex = 1'b0;
    check("flush_valid", bus.valid_ex, 0);
    check("flush_cnt", flush_cnt, 1);
    check("flush_stall_cnt", stall_cnt, 2);

    // x0 write is dropped but instruction stays valid
    set_id(32'h600, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 4'h1);
    step();
    check("x0_ruwr", bus.RUwr_ex, 0);
    check("x0_valid", bus.valid_ex, 1);

    // Saturation: 20 isolated load-use events
    exp_stall = 2;
    for (int i = 0; i < 20; i++) begin
      set_id(32'h700 + 32'(i * 8), 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0);
      step();
      set_id(32'h704 + 32'(i * 8), 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      if (exp_stall < 15) exp_stall++;
    end
    check("sat_stall_cnt", stall_cnt, 64'(exp_stall));
    set_id(32'h800, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    set_id(32'h804, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    check("sat_hold", stall_cnt, 15);
    check("sat_flush_cnt", flush_cnt, 1);

    // Reset while a stall is being requested
    set_id(32'h900, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    set_id(32'h904, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 4'h0);
    #1 check("mid_stall_pre", bus.stall_id, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_stall_clr", bus.stall_id, 0);
    check("mid_cnt_clr", {stall_cnt, flush_cnt}, 0);
    #2 rst_n = 1'b1;
    step();
    check("mid_reload_valid", bus.valid_ex, 1);
    check("mid_reload_rs1", bus.rs1_ex, 5);
    check("mid_reload_cnt", stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
